// File: rtl/hex_entry_pkg.sv
// hex_entry_pkg: shared types for the hex entry buffer.
// FSM state encoding, action enum and the input priority selector.
package hex_entry_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SEND = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ACT_NONE   = 3'd0,
    ACT_CLR    = 3'd1,
    ACT_BKSP   = 3'd2,
    ACT_COMMIT = 3'd3,
    ACT_DIGIT  = 3'd4
  } act_t;

  // clear > backspace > commit > digit
  function automatic act_t pickAct(
    input logic clr,
    input logic bksp,
    input logic commit,
    input logic key
  );
    if (clr)
      return ACT_CLR;
    else if (bksp)
      return ACT_BKSP;
    else if (commit)
      return ACT_COMMIT;
    else if (key)
      return ACT_DIGIT;
    else
      return ACT_NONE;
  endfunction

endpackage

// File: rtl/hex_entry_slot.sv
// hex_entry_slot: one entry slot, MSB-first digit register + saturating count.
// Ports: clk, rst (async active-low), wrEn/bkEn/clrEn, digit -> data, cnt.
module hex_entry_slot
  import hex_entry_pkg::*;
#(
  parameter int DIGITS = 16,
  parameter int CW     = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wrEn,
  input  logic                bkEn,
  input  logic                clrEn,
  input  logic [3:0]          digit,
  output logic [4*DIGITS-1:0] data,
  output logic [CW-1:0]       cnt
);

  logic [4*DIGITS-1:0] dNxt;
  logic [CW-1:0]       cNxt;

  // digit n (0-based) lives in nibble DIGITS-1-n
  always_comb begin
    dNxt = data;
    cNxt = cnt;
    if (clrEn) begin
      dNxt = '0;
      cNxt = '0;
    end else if (bkEn) begin
      if (cnt != '0) begin
        for (int i = 0; i < DIGITS; i++)
          if (i == DIGITS - int'(cnt))
            dNxt[4*i +: 4] = 4'h0;
        cNxt = cnt - 1'b1;
      end
    end else if (wrEn) begin
      if (int'(cnt) < DIGITS) begin
        for (int i = 0; i < DIGITS; i++)
          if (i == DIGITS - 1 - int'(cnt))
            dNxt[4*i +: 4] = digit;
        cNxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
      cnt  <= '0;
    end else begin
      data <= dNxt;
      cnt  <= cNxt;
    end
  end

endmodule

// File: rtl/hex_entry_buffer.sv
// hex_entry_buffer: multi-slot hex entry with one action per press and
// a valid/ready commit port. Ports: key/bksp/clr/commit inputs, sel,
// out_ready -> out_valid/out_data/out_slot, value/count/full/state.
// Option: HEX_ENTRY_AUTOCOMMIT_EN sends a slot as soon as it fills.
module hex_entry_buffer
  import hex_entry_pkg::*;
#(
  parameter int DIGITS = 16,
  parameter int SLOTS  = 2,
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int CW = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [3:0]          key_digit,
  input  logic                bksp_in,
  input  logic                clr_in,
  input  logic                commit_in,
  input  logic [SW-1:0]       sel,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [4*DIGITS-1:0] out_data,
  output logic [SW-1:0]       out_slot,
  output logic [4*DIGITS-1:0] value,
  output logic [CW-1:0]       count,
  output logic                full,
  output logic [1:0]          state
);

  state_t        st;
  logic [SW-1:0] act;
  logic [SW-1:0] selEff;
  act_t          action;
  logic          anyIn;

  logic [4*DIGITS-1:0] slotData [SLOTS];
  logic [CW-1:0]       slotCnt  [SLOTS];
  logic [SLOTS-1:0]    wrEn;
  logic [SLOTS-1:0]    bkEn;
  logic [SLOTS-1:0]    clrEn;

  assign selEff = (int'(sel) < SLOTS) ? sel : '0;
  assign action = pickAct(clr_in, bksp_in, commit_in, key_valid);
  assign anyIn  = key_valid | bksp_in | clr_in | commit_in;

  assign value = slotData[act];
  assign count = slotCnt[act];
  assign full  = (count == CW'(DIGITS));
  assign state = st;

  always_comb begin
    wrEn  = '0;
    bkEn  = '0;
    clrEn = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (st == IDLE && act == SW'(i)) begin
        wrEn[i]  = (action == ACT_DIGIT);
        bkEn[i]  = (action == ACT_BKSP);
        clrEn[i] = (action == ACT_CLR);
      end
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : gSlot
    hex_entry_slot #(
      .DIGITS(DIGITS),
      .CW    (CW)
    ) uSlot (
      .clk  (clk),
      .rst  (rst),
      .wrEn (wrEn[g]),
      .bkEn (bkEn[g]),
      .clrEn(clrEn[g]),
      .digit(key_digit),
      .data (slotData[g]),
      .cnt  (slotCnt[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      act       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_slot  <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          act <= selEff;
          unique case (action)
            ACT_NONE: st <= IDLE;
            ACT_CLR:  st <= HOLD;
            ACT_BKSP: st <= HOLD;
            ACT_COMMIT: begin
              if (full) begin
                st        <= SEND;
                out_valid <= 1'b1;
                out_data  <= value;
                out_slot  <= act;
              end else begin
                st <= HOLD;
              end
            end
            ACT_DIGIT: begin
`ifdef HEX_ENTRY_AUTOCOMMIT_EN
              // last digit always lands in nibble 0
              if (count == CW'(DIGITS - 1)) begin
                st        <= SEND;
                out_valid <= 1'b1;
                out_data  <= {value[4*DIGITS-1:4], key_digit};
                out_slot  <= act;
              end else begin
                st <= HOLD;
              end
`else
              st <= HOLD;
`endif
            end
            default: st <= IDLE;
          endcase
        end
        HOLD: begin
          if (!anyIn)
            st <= IDLE;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            st        <= HOLD;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_entry_buffer.sv
// tb_hex_entry_buffer: directed test of hex_entry_buffer.
// Linear stimulus, immediate assertions with hand-computed expectations.
module tb_hex_entry_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        bksp_in;
  logic        clr_in;
  logic        commit_in;
  logic [0:0]  sel;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic [0:0]  out_slot;
  logic [63:0] value;
  logic [4:0]  count;
  logic        full;
  logic [1:0]  state;

  int nAsserts = 0;
  int nFail    = 0;

  always #5 clk = ~clk;

  hex_entry_buffer #(
    .DIGITS(16),
    .SLOTS (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_digit(key_digit),
    .bksp_in  (bksp_in),
    .clr_in   (clr_in),
    .commit_in(commit_in),
    .sel      (sel),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_slot (out_slot),
    .value    (value),
    .count    (count),
    .full     (full),
    .state    (state)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pressKey(input logic [3:0] d);
    key_digit = d;
    key_valid = 1'b1;
    step(3);
    key_valid = 1'b0;
    step(1);
  endtask

  task automatic pressBksp();
    bksp_in = 1'b1;
    step(3);
    bksp_in = 1'b0;
    step(1);
  endtask

  task automatic pressClr();
    clr_in = 1'b1;
    step(3);
    clr_in = 1'b0;
    step(1);
  endtask

  logic [63:0] held;

  initial begin
    rst       = 1'b0;
    key_valid = 1'b0;
    key_digit = 4'h0;
    bksp_in   = 1'b0;
    clr_in    = 1'b0;
    commit_in = 1'b0;
    sel       = 1'b0;
    out_ready = 1'b1;
    step(2);
    chk("rst_value", value, 64'h0);
    chk("rst_count", count, 64'd0);
    chk("rst_state", state, 64'd0);
    chk("rst_valid", out_valid, 64'd0);
    chk("rst_data", out_data, 64'h0);
    chk("rst_slot", out_slot, 64'd0);
    rst = 1'b1;
    step(1);

    // fill slot 0 with 1..F,0
    for (int d = 1; d <= 16; d++)
      pressKey(4'(d));
    chk("fill_value", value, 64'h123456789ABCDEF0);
    chk("fill_count", count, 64'd16);
    chk("fill_full", full, 64'd1);
    chk("fill_novalid", out_valid, 64'd0);

    // commit with out_ready already high
    commit_in = 1'b1;
    step(1);
    chk("c0_valid", out_valid, 64'd1);
    chk("c0_data", out_data, 64'h123456789ABCDEF0);
    chk("c0_slot", out_slot, 64'd0);
    chk("c0_state", state, 64'd2);
    step(1);
    chk("c0_drop", out_valid, 64'd0);
    chk("c0_hold", state, 64'd1);
    chk("c0_count", count, 64'd16);
    commit_in = 1'b0;
    step(1);
    chk("c0_idle", state, 64'd0);

    // clear, enter A,B, backspace x3
    pressClr();
    chk("clr_value", value, 64'h0);
    chk("clr_count", count, 64'd0);
    pressKey(4'hA);
    pressKey(4'hB);
    chk("ab_value", value, 64'hAB00000000000000);
    chk("ab_count", count, 64'd2);
    pressBksp();
    chk("bk1_value", value, 64'hA000000000000000);
    chk("bk1_count", count, 64'd1);
    pressBksp();
    chk("bk2_value", value, 64'h0);
    chk("bk2_count", count, 64'd0);
    pressBksp();
    chk("bk3_value", value, 64'h0);
    chk("bk3_count", count, 64'd0);

    // slot 1: 16 x F then a dropped 7
    sel = 1'b1;
    step(1);
    chk("s1_count0", count, 64'd0);
    for (int d = 0; d < 16; d++)
      pressKey(4'hF);
    pressKey(4'h7);
    chk("s1_value", value, 64'hFFFFFFFFFFFFFFFF);
    chk("s1_count", count, 64'd16);
    sel = 1'b0;
    step(1);
    chk("s0_count", count, 64'd0);
    chk("s0_value", value, 64'h0);
    sel = 1'b1;
    step(1);
    chk("s1_kept", value, 64'hFFFFFFFFFFFFFFFF);

    // partial commit on slot 0 is ignored
    sel = 1'b0;
    step(1);
    for (int d = 1; d <= 5; d++)
      pressKey(4'(d));
    chk("p5_count", count, 64'd5);
    commit_in = 1'b1;
    step(1);
    chk("p5_novalid", out_valid, 64'd0);
    chk("p5_hold", state, 64'd1);
    step(2);
    chk("p5_novalid2", out_valid, 64'd0);
    commit_in = 1'b0;
    step(1);

    // full commit on slot 1 with a stalled sink
    sel = 1'b1;
    step(1);
    out_ready = 1'b0;
    commit_in = 1'b1;
    step(1);
    commit_in = 1'b0;
    chk("st_valid", out_valid, 64'd1);
    chk("st_slot", out_slot, 64'd1);
    held = out_data;
    chk("st_data", held, 64'hFFFFFFFFFFFFFFFF);
    key_digit = 4'h3;
    key_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(1);
      chk("st_wait_valid", out_valid, 64'd1);
      chk("st_wait_data", out_data, 64'hFFFFFFFFFFFFFFFF);
    end
    key_valid = 1'b0;
    chk("st_cnt", count, 64'd16);
    out_ready = 1'b1;
    step(1);
    chk("st_done", out_valid, 64'd0);
    chk("st_hold", state, 64'd1);
    step(1);
    chk("st_idle", state, 64'd0);
    chk("st_kept", value, 64'hFFFFFFFFFFFFFFFF);

    // clear and digit together, held 10 cycles
    clr_in    = 1'b1;
    key_valid = 1'b1;
    key_digit = 4'h5;
    step(10);
    clr_in    = 1'b0;
    key_valid = 1'b0;
    step(1);
    chk("ck_value", value, 64'h0);
    chk("ck_count", count, 64'd0);
    chk("ck_state", state, 64'd0);

    // reset in the middle of SEND
    sel = 1'b0;
    step(1);
    for (int d = 6; d <= 16; d++)
      pressKey(4'(d));
    chk("r_fill", value, 64'h123456789ABCDEF0);
    out_ready = 1'b0;
    commit_in = 1'b1;
    step(1);
    commit_in = 1'b0;
    chk("r_valid", out_valid, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("r_drop", out_valid, 64'd0);
    chk("r_count", count, 64'd0);
    chk("r_state", state, 64'd0);
    step(1);
    rst = 1'b1;
    out_ready = 1'b1;
    step(1);

`ifdef HEX_ENTRY_AUTOCOMMIT_EN
    // 16th digit sends without a commit
    out_ready = 1'b0;
    for (int d = 0; d < 15; d++)
      pressKey(4'h1);
    chk("ac_pre", out_valid, 64'd0);
    key_digit = 4'h9;
    key_valid = 1'b1;
    step(1);
    chk("ac_valid", out_valid, 64'd1);
    chk("ac_data", out_data, 64'h1111111111111119);
    key_valid = 1'b0;
    out_ready = 1'b1;
    step(1);
    chk("ac_done", out_valid, 64'd0);
    step(1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAsserts, nFail);
    $finish;
  end

endmodule
